// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic REDIR_REL = 1'b0;
    localparam logic REDIR_ABS = 1'b1;

endpackage : fetch_pkg

// File: rtl/instr_rom.sv
// Byte-organised instruction ROM with a combinational big-endian word read.
module instr_rom
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES     = 1024,
    parameter string       MEM_INIT_FILE = ""
) (
    input  logic [$clog2(MEM_BYTES)-1:0] addr,
    output logic [INSTR_W-1:0]           word
);

    localparam int unsigned AW = $clog2(MEM_BYTES);

    logic [7:0]    r_mem [MEM_BYTES];
    logic [AW-1:0] w_base;

    // Word base is forced to a 4-byte boundary; the fetch stage only reads aligned words.
    always_comb begin
        w_base = addr & ~AW'(3);
        word   = {r_mem[w_base],
                  r_mem[w_base + AW'(1)],
                  r_mem[w_base + AW'(2)],
                  r_mem[w_base + AW'(3)]};
    end

endmodule : instr_rom

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: fetch PC, ROM read, decode handshake, redirect/flush,
// sticky fault and retired-instruction counter.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W          = 32,
    parameter int unsigned     MEM_BYTES     = 1024,
    parameter logic [PC_W-1:0] RESET_PC      = '0,
    parameter string           MEM_INIT_FILE = "",
    parameter int unsigned     CNT_W         = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_en,
    input  logic               redirect_abs,
    input  logic [PC_W-1:0]    redirect_target,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    fetch_pc,
    output logic               fault,
    output logic [CNT_W-1:0]   retired
);

    localparam int unsigned     AW      = $clog2(MEM_BYTES);
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(MEM_BYTES - INSTR_BYTES);

    logic [PC_W-1:0]    r_fetch_pc;
    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_instr;
    logic [PC_W-1:0]    r_out_pc;
    logic               r_fault;
    logic [CNT_W-1:0]   r_retired;

    logic [INSTR_W-1:0] w_rom_word;
    logic [AW-1:0]      w_rom_addr;
    logic [PC_W-1:0]    w_target;
    logic               w_hs;
    logic               w_redir;
    logic               w_adv;
    logic               w_fetch_ok;

    logic [PC_W-1:0]    w_fetch_pc_nxt;
    logic               w_out_valid_nxt;
    logic [INSTR_W-1:0] w_out_instr_nxt;
    logic [PC_W-1:0]    w_out_pc_nxt;
    logic               w_fault_nxt;
    logic [CNT_W-1:0]   w_retired_nxt;

    assign w_rom_addr = r_fetch_pc[AW-1:0];

    instr_rom #(
        .MEM_BYTES     (MEM_BYTES),
        .MEM_INIT_FILE (MEM_INIT_FILE)
    ) u_rom (
        .addr (w_rom_addr),
        .word (w_rom_word)
    );

    // Next-state: redirect (flush) beats advance; a faulted unit ignores both.
    always_comb begin
        w_fetch_pc_nxt  = r_fetch_pc;
        w_out_valid_nxt = r_out_valid;
        w_out_instr_nxt = r_out_instr;
        w_out_pc_nxt    = r_out_pc;
        w_fault_nxt     = r_fault;
        w_retired_nxt   = r_retired;

        w_hs       = r_out_valid && out_ready;
        w_redir    = redirect_en && !r_fault;
        w_adv      = !r_fault && !redirect_en && (!r_out_valid || out_ready);
        w_fetch_ok = (r_fetch_pc[1:0] == 2'b00) && (r_fetch_pc <= LAST_PC);
        w_target   = (redirect_abs == REDIR_ABS) ? redirect_target
                                                 : r_out_pc + redirect_target;

        if (w_hs) begin
            w_retired_nxt = r_retired + CNT_W'(1);
        end

        if (w_redir) begin
            w_fetch_pc_nxt  = w_target;
            w_out_valid_nxt = 1'b0;
        end else if (w_adv) begin
            if (w_fetch_ok) begin
                w_out_instr_nxt = w_rom_word;
                w_out_pc_nxt    = r_fetch_pc;
                w_out_valid_nxt = 1'b1;
                w_fetch_pc_nxt  = r_fetch_pc + PC_W'(INSTR_BYTES);
            end else begin
                w_fault_nxt     = 1'b1;
                w_out_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
            r_fault     <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_instr <= w_out_instr_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_fault     <= w_fault_nxt;
            r_retired   <= w_retired_nxt;
        end
    end

    assign fetch_pc  = r_fetch_pc;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign fault     = r_fault;
    assign retired   = r_retired;

endmodule : pc_fetch_unit
